// File: rtl/wb_select_stage.sv
// ----------------------------------------------------------------------------
// wb_select_stage
//   MEM/WB pipeline register merged with an N-source priority write-back
//   select. The stage picks one of NUM_SRC source words, applies the
//   load-extension mode, and registers the result together with the
//   destination index and the qualified write enable. The output is visible
//   one cycle after capture. The stage also provides stall, flush,
//   register-0 write suppression and a saturating counter of retired writes.
//
// Ports
//   Clk           rising-edge clock
//   Reset         asynchronous, active-high reset
//   Stall         hold stage contents this cycle
//   Flush         squash the incoming instruction (insert a bubble)
//   in_valid      MEM-stage instruction valid
//   in_data       packed sources; src k = in_data[k*DATA_W +: DATA_W]
//   in_sel        in_sel[k-1] high selects src k; highest set bit wins
//   in_ext_mode   0 word, 1 byte sext, 2 byte zext, 3 half sext, 4 half zext
//   in_reg_write  instruction writes the register file
//   in_dst        destination register index
//   wb_valid      registered valid
//   wb_data       registered selected/extended data
//   wb_dst        registered destination
//   wb_reg_write  registered, qualified write enable
//   wb_count      saturating count of retired register writes
// ----------------------------------------------------------------------------
module wb_select_stage #(
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16,
  parameter int ZERO_REG   = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      in_valid,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [NUM_SRC-2:0]        in_sel,
  input  logic [2:0]                in_ext_mode,
  input  logic                      in_reg_write,
  input  logic [REG_ADDR_W-1:0]     in_dst,
  output logic                      wb_valid,
  output logic [DATA_W-1:0]         wb_data,
  output logic [REG_ADDR_W-1:0]     wb_dst,
  output logic                      wb_reg_write,
  output logic [CNT_W-1:0]          wb_count
);

  // Sign-bit positions; narrow words fall back to their own MSB so that the
  // half modes degrade to a plain word pass-through when DATA_W < 16.
  localparam int BYTE_MSB = (DATA_W >= 8)  ? 7  : DATA_W - 1;
  localparam int HALF_MSB = (DATA_W >= 16) ? 15 : DATA_W - 1;

  typedef enum logic [2:0] {
    EXT_WORD  = 3'd0,
    EXT_BYTE_S = 3'd1,
    EXT_BYTE_Z = 3'd2,
    EXT_HALF_S = 3'd3,
    EXT_HALF_Z = 3'd4
  } ext_mode_e;

  logic [DATA_W-1:0] sel_word;
  logic [DATA_W-1:0] ext_word;
  logic              write_qual;

  // Priority select: ascending scan so the highest asserted bit overrides.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel_word = in_data[DATA_W-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (in_sel[k-1]) sel_word = in_data[k*DATA_W +: DATA_W];
    end
  end

  // Load extension; modes 5-7 pass the word through unchanged.
  always_comb begin
    ext_word = sel_word;
    case (ext_mode_e'(in_ext_mode))
      EXT_BYTE_S: for (int i = 8; i < DATA_W; i++) ext_word[i] = sel_word[BYTE_MSB];
      EXT_BYTE_Z: for (int i = 8; i < DATA_W; i++) ext_word[i] = 1'b0;
      EXT_HALF_S: for (int i = 16; i < DATA_W; i++) ext_word[i] = sel_word[HALF_MSB];
      EXT_HALF_Z: for (int i = 16; i < DATA_W; i++) ext_word[i] = 1'b0;
      default:    ext_word = sel_word;
    endcase
  end

  assign write_qual = in_valid && in_reg_write &&
                      !((ZERO_REG != 0) && (in_dst == '0));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_dst       <= '0;
      wb_reg_write <= 1'b0;
      wb_count     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values; the counter below relies on
      // seeing the old wb_reg_write.
      if (Flush) begin
        // Bubble: kill valid/write, keep data and dst as they were.
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
      end else if (!Stall) begin
        wb_valid     <= in_valid;
        wb_data      <= ext_word;
        wb_dst       <= in_dst;
        wb_reg_write <= write_qual;
      end

      // A write retires on the edge that moves it out of the stage; a
      // stalled write is therefore counted once, when the stall drops.
      if (wb_reg_write && !Stall && (wb_count != '1)) begin
        wb_count <= wb_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        in_valid;
  logic [95:0] in_data;
  logic [1:0]  in_sel;
  logic [2:0]  in_ext_mode;
  logic        in_reg_write;
  logic [4:0]  in_dst;

  logic        wb_valid,     wb_valid_b;
  logic [31:0] wb_data,      wb_data_b;
  logic [4:0]  wb_dst,       wb_dst_b;
  logic        wb_reg_write, wb_reg_write_b;
  logic [15:0] wb_count;
  logic [3:0]  wb_count_b;

  int total = 0;
  int bad   = 0;

  // Expected-state tracking (hand-set outputs, small counter model).
  logic [31:0] exp_data;
  logic [4:0]  exp_dst;
  logic        exp_rw;
  logic        exp_valid;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt_b;

  wb_select_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel),
    .in_ext_mode(in_ext_mode), .in_reg_write(in_reg_write), .in_dst(in_dst),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst(wb_dst),
    .wb_reg_write(wb_reg_write), .wb_count(wb_count)
  );

  wb_select_stage #(.CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel),
    .in_ext_mode(in_ext_mode), .in_reg_write(in_reg_write), .in_dst(in_dst),
    .wb_valid(wb_valid_b), .wb_data(wb_data_b), .wb_dst(wb_dst_b),
    .wb_reg_write(wb_reg_write_b), .wb_count(wb_count_b)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] s0, s1, s2;
    logic [1:0]  sel;
    logic [2:0]  mode;
    logic [4:0]  dst;
    logic        valid;
    logic        rw;
    logic [31:0] e_data;
    logic        e_rw;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " data"},  64'(wb_data),      64'(exp_data));
    check({tag, " dst"},   64'(wb_dst),       64'(exp_dst));
    check({tag, " rw"},    64'(wb_reg_write), 64'(exp_rw));
    check({tag, " valid"}, 64'(wb_valid),     64'(exp_valid));
    check({tag, " count"}, 64'(wb_count),     64'(exp_cnt));
  endtask

  // One rising edge; counter expectation advances when the currently
  // registered write leaves the stage (no Stall). Samples at +1.
  task automatic tick();
    if (exp_rw && !Stall) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt_b != 4'hF)   exp_cnt_b = exp_cnt_b + 4'd1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [1:0] sel, input logic [2:0] mode, input logic [4:0] dst,
                       input logic valid, input logic rw);
    in_data      = {s2, s1, s0};
    in_sel       = sel;
    in_ext_mode  = mode;
    in_dst       = dst;
    in_valid     = valid;
    in_reg_write = rw;
  endtask

  task automatic set_exp(input logic [31:0] d, input logic [4:0] dst, input logic rw,
                         input logic v);
    exp_data  = d;
    exp_dst   = dst;
    exp_rw    = rw;
    exp_valid = v;
  endtask

  task automatic clear_exp();
    set_exp(32'h0, 5'd0, 1'b0, 1'b0);
    exp_cnt   = 16'h0;
    exp_cnt_b = 4'h0;
  endtask

  vec_t vecs[16];
  logic [15:0] saved_cnt;

  initial begin
    vecs[0]  = '{32'h11, 32'h22, 32'h33, 2'b11, 3'd0, 5'd5,  1'b1, 1'b1, 32'h33, 1'b1};
    vecs[1]  = '{32'h11, 32'h22, 32'h33, 2'b00, 3'd0, 5'd5,  1'b1, 1'b1, 32'h11, 1'b1};
    vecs[2]  = '{32'h11, 32'h22, 32'h33, 2'b01, 3'd0, 5'd6,  1'b1, 1'b1, 32'h22, 1'b1};
    vecs[3]  = '{32'h11, 32'h22, 32'h33, 2'b10, 3'd0, 5'd6,  1'b1, 1'b1, 32'h33, 1'b1};
    vecs[4]  = '{32'h11, 32'h0000_80F0, 32'h33, 2'b01, 3'd1, 5'd2, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b1};
    vecs[5]  = '{32'h11, 32'h0000_80F0, 32'h33, 2'b01, 3'd2, 5'd2, 1'b1, 1'b1, 32'h0000_00F0, 1'b1};
    vecs[6]  = '{32'h11, 32'h0000_80F0, 32'h33, 2'b01, 3'd3, 5'd2, 1'b1, 1'b1, 32'hFFFF_80F0, 1'b1};
    vecs[7]  = '{32'h11, 32'h0000_80F0, 32'h33, 2'b01, 3'd4, 5'd2, 1'b1, 1'b1, 32'h0000_80F0, 1'b1};
    vecs[8]  = '{32'h11, 32'h0000_80F0, 32'h33, 2'b01, 3'd5, 5'd2, 1'b1, 1'b1, 32'h0000_80F0, 1'b1};
    vecs[9]  = '{32'h8765_A3C4, 32'h22, 32'h33, 2'b00, 3'd7, 5'd3, 1'b1, 1'b1, 32'h8765_A3C4, 1'b1};
    vecs[10] = '{32'h1234_5678, 32'h22, 32'h33, 2'b00, 3'd1, 5'd3, 1'b1, 1'b1, 32'h0000_0078, 1'b1};
    vecs[11] = '{32'h1234_5678, 32'h22, 32'h33, 2'b00, 3'd3, 5'd3, 1'b1, 1'b1, 32'h0000_5678, 1'b1};
    vecs[12] = '{32'h11, 32'h22, 32'h44, 2'b10, 3'd0, 5'd0,  1'b1, 1'b1, 32'h44, 1'b0};
    vecs[13] = '{32'h11, 32'h22, 32'h44, 2'b10, 3'd0, 5'd7,  1'b1, 1'b1, 32'h44, 1'b1};
    vecs[14] = '{32'hAB, 32'h22, 32'h33, 2'b00, 3'd0, 5'd3,  1'b0, 1'b1, 32'hAB, 1'b0};
    vecs[15] = '{32'hCD, 32'h22, 32'h33, 2'b00, 3'd0, 5'd4,  1'b1, 1'b0, 32'hCD, 1'b0};

    // Reset out of time zero
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 2'b00, 3'd0, 5'd0, 1'b0, 1'b0);
    clear_exp();
    repeat (2) @(posedge Clk);
    #1;
    check_all("reset");
    Reset = 1'b0;

    // Table-driven select / extension / zero-register / invalid vectors
    foreach (vecs[i]) begin
      drive(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].sel, vecs[i].mode,
            vecs[i].dst, vecs[i].valid, vecs[i].rw);
      tick();
      set_exp(vecs[i].e_data, vecs[i].dst, vecs[i].e_rw, vecs[i].valid);
      check_all($sformatf("vec%0d", i));
    end

    // Register-0 write leaves the counter alone on the following edge
    drive(32'h5, 32'h0, 32'h0, 2'b00, 3'd0, 5'd0, 1'b1, 1'b1);
    tick();
    set_exp(32'h5, 5'd0, 1'b0, 1'b1);
    saved_cnt = wb_count;
    tick();
    check("zero_reg count held", 64'(wb_count), 64'(saved_cnt));

    // Stall: load one write, then freeze for 3 edges with changing inputs
    drive(32'h55, 32'h0, 32'h0, 2'b00, 3'd0, 5'd9, 1'b1, 1'b1);
    tick();
    set_exp(32'h55, 5'd9, 1'b1, 1'b1);
    check_all("stall load");
    saved_cnt = wb_count;
    Stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(32'h100 + 32'(n), 32'h200, 32'h300, 2'(n), 3'd0, 5'(20 + n), 1'b1, 1'b1);
      tick();
      check_all($sformatf("stall hold%0d", n));
    end
    Stall = 1'b0;
    drive(32'h66, 32'h0, 32'h0, 2'b00, 3'd0, 5'd10, 1'b1, 1'b0);
    tick();
    set_exp(32'h66, 5'd10, 1'b0, 1'b1);
    check_all("stall release");
    check("stall count once", 64'(wb_count), 64'(saved_cnt + 16'd1));

    // Flush + Stall together: bubble wins, counter follows the stall rule
    drive(32'h77, 32'h0, 32'h0, 2'b00, 3'd0, 5'd11, 1'b1, 1'b1);
    tick();
    set_exp(32'h77, 5'd11, 1'b1, 1'b1);
    check_all("fs load");
    Flush = 1'b1; Stall = 1'b1;
    drive(32'h88, 32'h0, 32'h0, 2'b00, 3'd0, 5'd12, 1'b1, 1'b1);
    tick();
    set_exp(32'h77, 5'd11, 1'b0, 1'b0);
    check_all("flush+stall");
    Stall = 1'b0;
    tick();
    check_all("flush only bubble");
    Flush = 1'b0;

    // Flush alone retires the registered write
    drive(32'h99, 32'h0, 32'h0, 2'b00, 3'd0, 5'd13, 1'b1, 1'b1);
    tick();
    set_exp(32'h99, 5'd13, 1'b1, 1'b1);
    check_all("flush pre");
    Flush = 1'b1;
    tick();
    set_exp(32'h99, 5'd13, 1'b0, 1'b0);
    check_all("flush retire");
    Flush = 1'b0;

    // Async reset mid-cycle during a stall
    drive(32'h3C, 32'h0, 32'h0, 2'b00, 3'd0, 5'd15, 1'b1, 1'b1);
    tick();
    set_exp(32'h3C, 5'd15, 1'b1, 1'b1);
    Stall = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    clear_exp();
    check_all("async reset");
    check("async reset count_b", 64'(wb_count_b), 64'(0));
    @(posedge Clk);
    #1;
    Reset = 1'b0; Stall = 1'b0;
    drive(32'hAA, 32'h0, 32'h0, 2'b00, 3'd0, 5'd14, 1'b1, 1'b1);
    tick();
    set_exp(32'hAA, 5'd14, 1'b1, 1'b1);
    check_all("post reset load");

    // Saturation of the 4-bit counter over 20 consecutive writes
    Reset = 1'b1;
    #1;
    clear_exp();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      drive(32'(n), 32'h0, 32'h0, 2'b00, 3'd0, 5'd1, 1'b1, 1'b1);
      tick();
      set_exp(32'(n), 5'd1, 1'b1, 1'b1);
      check($sformatf("sat cnt_b%0d", n), 64'(wb_count_b), 64'(exp_cnt_b));
    end
    check("sat final_b", 64'(wb_count_b), 64'(4'hF));
    check("sat final_a", 64'(wb_count), 64'(19));
    tick();
    check("sat no wrap", 64'(wb_count_b), 64'(4'hF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
